// File: rtl/mem_bus_arbiter.sv
// Arbiter and transaction sequencer between the instruction-fetch and
// data requesters and a single Avalon-style memory master port.
// One transaction at a time: IDLE -> ACCESS -> RESP -> IDLE, with
// round-robin on ties and a sticky watchdog for long stalls.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,

  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,

  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,

  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  // Counter saturates at the trip value; the flag sets when the count
  // would reach TIMEOUT_CYCLES-1 with waitrequest still high.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  state_t           state;
  owner_t           owner;
  owner_t           last_owner;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_data;

  // Data wins when it asks alone, or on a tie when fetch went last.
  assign grant_data = d_req && (!f_req || (last_owner == OWN_FETCH));

  // Sequencer: the avm_* registers double as the latched command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      owner          <= OWN_FETCH;
      last_owner     <= OWN_DATA;
      wait_cnt       <= '0;
      f_done         <= 1'b0;
      d_done         <= 1'b0;
      f_rdata        <= '0;
      d_rdata        <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (f_req || d_req) begin
            state    <= S_ACCESS;
            busy     <= 1'b1;
            wait_cnt <= '0;
            if (grant_data) begin
              owner          <= OWN_DATA;
              avm_address    <= d_addr;
              avm_read       <= !d_write;
              avm_write      <= d_write;
              avm_byteenable <= d_byteenable;
              avm_writedata  <= d_wdata;
            end else begin
              owner          <= OWN_FETCH;
              avm_address    <= f_addr;
              avm_read       <= 1'b1;
              avm_write      <= 1'b0;
              avm_byteenable <= 4'hF;
              avm_writedata  <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (avm_waitrequest) begin
            if (wait_cnt != CNT_MAX) begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (wait_cnt >= CNT_TRIP) begin
              timeout_err <= 1'b1;
            end
          end else begin
            if (avm_read) begin
              if (owner == OWN_DATA) begin
                d_rdata <= avm_readdata;
              end else begin
                f_rdata <= avm_readdata;
              end
            end
            if (owner == OWN_DATA) begin
              d_done <= 1'b1;
            end else begin
              f_done <= 1'b1;
            end
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
            state          <= S_RESP;
          end
        end
        S_RESP: begin
          last_owner <= owner;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations,
// plus a transaction-level model compared against the DUT every cycle.
module tb_mem_bus_arbiter;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        f_done;
  logic [31:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_byteenable = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        busy;
  logic        timeout_err;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr),
    .d_byteenable(d_byteenable), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int stall_cfg = 0;
  int stall_ctr = 0;
  logic [31:0] rd_value = '0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory slave: stalls each access for stall_cfg cycles, then answers.
  always @(negedge clk) begin
    if (avm_read || avm_write) begin
      if (stall_ctr < stall_cfg) begin
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'hDEADBEEF;
        stall_ctr++;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata    = rd_value;
        stall_ctr       = 0;
      end
    end else begin
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'h0;
      stall_ctr       = 0;
    end
  end

  // Transaction-level reference: one outstanding command, then a done cycle.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

  bit          m_active, m_resp, m_own_d, m_tie_d, m_tmo;
  cmd_t        m_cmd;
  int          m_stalls;
  logic [31:0] m_frd, m_drd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_resp = 0; m_own_d = 0; m_tie_d = 0; m_tmo = 0;
      m_cmd = '0; m_stalls = 0; m_frd = '0; m_drd = '0;
    end else if (m_resp) begin
      m_resp  = 0;
      m_tie_d = !m_own_d;
    end else if (m_active) begin
      if (avm_waitrequest) begin
        m_stalls++;
        if (m_stalls >= int'(TMO) - 1) m_tmo = 1;
      end else begin
        if (!m_cmd.write) begin
          if (m_own_d) m_drd = avm_readdata;
          else         m_frd = avm_readdata;
        end
        m_active = 0;
        m_resp   = 1;
      end
    end else if (f_req || d_req) begin
      m_own_d = d_req && (!f_req || m_tie_d);
      if (m_own_d) m_cmd = '{addr: d_addr, write: d_write, be: d_byteenable, wdata: d_wdata};
      else         m_cmd = '{addr: f_addr, write: 1'b0, be: 4'hF, wdata: 32'h0};
      m_active = 1;
      m_stalls = 0;
    end
  end

  // Every-cycle comparison of all outputs against the reference.
  always @(posedge clk) begin
    logic [137:0] exp;
    #1;
    exp = {m_resp && !m_own_d, m_resp && m_own_d, m_active || m_resp, m_tmo,
           m_active && !m_cmd.write, m_active && m_cmd.write,
           m_active ? m_cmd.addr : 32'h0, m_active ? m_cmd.be : 4'h0,
           m_active ? m_cmd.wdata : 32'h0, m_frd, m_drd};
    chk("cycle_model", {f_done, d_done, busy, timeout_err, avm_read, avm_write,
                        avm_address, avm_byteenable, avm_writedata, f_rdata, d_rdata}, exp);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; stall_cfg = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input bit is_d, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if ((is_d && d_done) || (!is_d && f_done)) break;
    end
    if (k == budget) begin
      n_total++;
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
    end
  endtask

  // Issue one request, hold it until done, drop it inside the done cycle.
  task automatic run_txn(input bit is_d, input bit wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_write = wr; d_addr = addr; d_byteenable = be; d_wdata = wd;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    wait_done(is_d, 40);
    @(negedge clk);
    f_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq;
    int         n_seen;

    // Reset values
    @(posedge clk); #1;
    chk("reset_outputs", {f_done, d_done, busy, timeout_err, avm_read, avm_write,
                          avm_address, avm_byteenable, avm_writedata, f_rdata, d_rdata}, '0);
    @(negedge clk); rst_n = 1'b1;

    // Single fetch, zero wait states
    do_reset();
    @(negedge clk);
    rd_value = 32'h24020005; f_req = 1'b1; f_addr = 32'hBFC00000;
    @(posedge clk); #1;
    chk("fetch_bus", {avm_read, avm_write, avm_byteenable, avm_address, busy},
        {1'b1, 1'b0, 4'hF, 32'hBFC00000, 1'b1});
    @(posedge clk); #1;
    chk("fetch_done", {f_done, d_done, avm_read, f_rdata}, {1'b1, 1'b0, 1'b0, 32'h24020005});
    @(negedge clk); f_req = 1'b0;
    @(posedge clk); #1;
    chk("fetch_pulse_end", {f_done, busy}, 2'b00);

    // Store with three wait states
    do_reset();
    @(negedge clk);
    stall_cfg = 3; rd_value = 32'h77777777;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h1000; d_byteenable = 4'b0100; d_wdata = 32'h00AB0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("store_hold_%0d", i),
          {avm_read, avm_write, avm_address, avm_byteenable, avm_writedata, timeout_err},
          {1'b0, 1'b1, 32'h1000, 4'b0100, 32'h00AB0000, 1'(i == 3)});
    end
    @(posedge clk); #1;
    chk("store_done", {d_done, f_done, avm_write, d_rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk); d_req = 1'b0; stall_cfg = 0;
    @(posedge clk); #1;
    chk("store_pulse_end", d_done, 1'b0);

    // Simultaneous requests held continuously: grants alternate
    do_reset();
    @(negedge clk);
    rd_value = 32'h11112222;
    f_req = 1'b1; f_addr = 32'h400;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h800; d_byteenable = 4'hF; d_wdata = '0;
    @(posedge clk); #1;
    chk("tie_first_addr", avm_address, 32'h400);
    seq = '0; n_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (f_done || d_done) begin
        if (n_seen < 4) seq[n_seen] = d_done;
        n_seen++;
      end
    end
    chk("tie_order", {32'(n_seen), seq}, {32'd4, 4'b1010});
    @(negedge clk); f_req = 1'b0; d_req = 1'b0;

    // Watchdog with a 10-cycle stall
    do_reset();
    @(negedge clk);
    stall_cfg = 10; rd_value = 32'hA5A5A5A5; f_req = 1'b1; f_addr = 32'h40;
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("wd_edge_%0d", k), {timeout_err, avm_read}, {1'(k == 3), 1'b1});
    end
    wait_done(1'b0, 20);
    chk("wd_done", {f_done, timeout_err, f_rdata}, {1'b1, 1'b1, 32'hA5A5A5A5});
    @(negedge clk); f_req = 1'b0; stall_cfg = 0;
    @(posedge clk); #1;
    chk("wd_sticky", timeout_err, 1'b1);

    // Reset mid-access, then a normal fetch
    do_reset();
    @(negedge clk);
    stall_cfg = 5; f_req = 1'b1; f_addr = 32'h100;
    @(posedge clk);
    @(posedge clk); #3;
    chk("rst_pre", {avm_read, busy}, 2'b11);
    rst_n = 1'b0; f_req = 1'b0;
    #1;
    chk("rst_async", {avm_read, busy, f_done, d_done}, 4'b0000);
    @(negedge clk); rst_n = 1'b1; stall_cfg = 0; rd_value = 32'h0F0F0F0F;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_quiet_%0d", i), {f_done, busy}, 2'b00);
    end
    run_txn(1'b0, 1'b0, 32'h104, 4'h0, 32'h0);
    chk("rst_refetch", {f_done, f_rdata}, {1'b1, 32'h0F0F0F0F});

    // Load then store: d_rdata keeps the load, f_rdata untouched
    do_reset();
    rd_value = 32'hCAFEF00D;
    run_txn(1'b1, 1'b0, 32'h2000, 4'hF, 32'h0);
    chk("load_data", {d_done, d_rdata, f_rdata}, {1'b1, 32'hCAFEF00D, 32'h0});
    rd_value = 32'h55AA55AA;
    run_txn(1'b1, 1'b1, 32'h2004, 4'h3, 32'h00001234);
    chk("store_keeps", {d_done, d_rdata, f_rdata}, {1'b1, 32'hCAFEF00D, 32'h0});
    run_txn(1'b1, 1'b1, 32'h3001, 4'h0, 32'hFFFFFFFF);
    chk("zero_be_store", {d_done, d_rdata}, {1'b1, 32'hCAFEF00D});
    rd_value = 32'h0BADF00D;
    run_txn(1'b0, 1'b0, 32'h3000, 4'h0, 32'h0);
    chk("fetch_after_data", {f_done, f_rdata, d_rdata}, {1'b1, 32'h0BADF00D, 32'hCAFEF00D});

    @(posedge clk); #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
